calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 168 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad calculator sequencer driving a shared external 4-bit adder
module calc_sequencer (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] keycode,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_carry,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_OP = 2'd1,
    WAIT_B  = 2'd2,
    EXEC    = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_MUL = 4'd11;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_mul;
  logic [8:0] p;
  logic [1:0] step_cnt;

  logic       is_digit;
  logic       is_op;
  logic       load_a;
  logic       load_op;
  logic       load_b;
  logic       mul_step;
  logic       done;
  logic       reject;
  logic [8:0] p_shift;

  // The shift always clears P[8], so it is carried for width only and never consumed.
  logic       unused_p_msb;

  assign is_digit     = (keycode <= 4'd9);
  assign is_op        = (keycode == KEY_ADD) || (keycode == KEY_MUL);
  assign p_shift      = {add_carry, add_sum, p[3:0]} >> 1;
  assign unused_p_msb = p[8];
  assign busy         = (state_q == EXEC);
  assign state        = state_q;

  // State register; reset wins over any key in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode, datapath strobes and adder operand steering.
  always_comb begin
    state_d  = state_q;
    load_a   = 1'b0;
    load_op  = 1'b0;
    load_b   = 1'b0;
    mul_step = 1'b0;
    done     = 1'b0;
    reject   = 1'b0;
    add_a    = 4'd0;
    add_b    = 4'd0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (is_digit) begin
            load_a  = 1'b1;
            state_d = WAIT_OP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      WAIT_OP: begin
        if (key_valid) begin
          if (is_digit) begin
            load_a = 1'b1;
          end else if (is_op) begin
            load_op = 1'b1;
            state_d = WAIT_B;
          end else begin
            reject = 1'b1;
          end
        end
      end
      WAIT_B: begin
        if (key_valid) begin
          if (is_digit) begin
            load_b  = 1'b1;
            state_d = EXEC;
          end else if (is_op) begin
            load_op = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
      end
      EXEC: begin
        reject = key_valid;
        if (op_mul) begin
          // Shift-and-add: accumulate into the high nibble when the current multiplier bit is set.
          add_a    = p[7:4];
          add_b    = p[0] ? op_a : 4'd0;
          mul_step = 1'b1;
          if (step_cnt == 2'd3) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          add_a   = op_a;
          add_b   = op_b;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand, product, counter and result registers plus the registered status pulses.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      op_a         <= 4'd0;
      op_b         <= 4'd0;
      op_mul       <= 1'b0;
      p            <= 9'd0;
      step_cnt     <= 2'd0;
      result       <= 8'd0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      err          <= reject;
      result_valid <= done;
      if (load_a) begin
        op_a <= keycode;
      end
      if (load_op) begin
        op_mul <= (keycode == KEY_MUL);
      end
      if (load_b) begin
        op_b     <= keycode;
        p        <= {5'b0, keycode};
        step_cnt <= 2'd0;
      end
      if (mul_step) begin
        p        <= p_shift;
        step_cnt <= step_cnt + 2'd1;
      end
      if (done) begin
        result <= op_mul ? p_shift[7:0] : {3'b0, add_carry, add_sum};
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer
module tb_calc_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] keycode = 4'd0;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_carry;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: operands, chosen operation and remaining execute cycles.
  int m_phase, m_a, m_b, m_left, m_result;
  bit m_mul, m_rv, m_err;

  typedef struct {
    logic       r;
    logic       kv;
    logic [3:0] kc;
    logic [1:0] st;
    logic [7:0] res;
    logic       rv;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  calc_sequencer dut (
    .CLOCK_50    (CLOCK_50),
    .rst         (rst),
    .key_valid   (key_valid),
    .keycode     (keycode),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_sum     (add_sum),
    .add_carry   (add_carry),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .err         (err),
    .state       (state)
  );

  // External ripple adder, carry-in 0.
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic kv, input logic [3:0] kc);
    int k;
    k = int'(kc);
    if (r) begin
      m_phase = 0; m_a = 0; m_b = 0; m_mul = 0; m_left = 0;
      m_result = 0; m_rv = 0; m_err = 0;
    end else begin
      m_rv = 0;
      m_err = 0;
      if (m_phase == 3) begin
        if (kv) m_err = 1;
        m_left--;
        if (m_left == 0) begin
          m_result = m_mul ? m_a * m_b : m_a + m_b;
          m_rv = 1;
          m_phase = 0;
        end
      end else if (kv) begin
        if (k >= 12) m_err = 1;
        else begin
          case (m_phase)
            0: if (k <= 9) begin m_a = k; m_phase = 1; end else m_err = 1;
            1: if (k <= 9) m_a = k; else begin m_mul = (k == 11); m_phase = 2; end
            2: if (k <= 9) begin m_b = k; m_left = m_mul ? 4 : 1; m_phase = 3; end
               else m_mul = (k == 11);
            default: ;
          endcase
        end
      end
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later.
  task automatic tick(input logic r, input logic kv, input logic [3:0] kc);
    rst = r;
    key_valid = kv;
    keycode = kc;
    @(posedge CLOCK_50);
    #1;
    model_step(r, kv, kc);
  endtask

  task automatic check_model(input string tag);
    int k, ea, eb;
    ea = 0;
    eb = 0;
    if (m_phase == 3) begin
      if (m_mul) begin
        k  = 4 - m_left;
        ea = (m_a * (m_b % (1 << k))) >> k;
        eb = ((m_b >> k) & 1) ? m_a : 0;
      end else begin
        ea = m_a;
        eb = m_b;
      end
    end
    chk({tag, "_state"}, 16'(state), 16'(m_phase));
    chk({tag, "_result"}, 16'(result), 16'(m_result));
    chk({tag, "_rv"}, 16'(result_valid), 16'(m_rv));
    chk({tag, "_err"}, 16'(err), 16'(m_err));
    chk({tag, "_busy"}, 16'(busy), 16'(m_phase == 3));
    chk({tag, "_add_a"}, 16'(add_a), 16'(ea));
    chk({tag, "_add_b"}, 16'(add_b), 16'(eb));
  endtask

  task automatic add(input logic r, input logic kv, input logic [3:0] kc,
                     input logic [1:0] st, input logic [7:0] res, input logic rv, input logic er);
    vec_t v;
    v.r = r; v.kv = kv; v.kc = kc; v.st = st; v.res = res; v.rv = rv; v.er = er;
    tbl.push_back(v);
  endtask

  initial begin
    int cyc, pulses, rvs;
    int eb9[4];
    logic r, kv;
    logic [3:0] kc;
    int sel;

    // reset and rst-over-key priority
    add(1, 0, 0,  0, 8'h00, 0, 0);
    add(1, 1, 3,  0, 8'h00, 0, 0);
    // 3 ADD 4
    add(0, 1, 3,  1, 8'h00, 0, 0);
    add(0, 1, 10, 2, 8'h00, 0, 0);
    add(0, 1, 4,  3, 8'h00, 0, 0);
    add(0, 0, 0,  0, 8'h07, 1, 0);
    add(0, 0, 0,  0, 8'h07, 0, 0);
    // operator in IDLE
    add(0, 1, 10, 0, 8'h07, 0, 1);
    add(0, 0, 0,  0, 8'h07, 0, 0);
    // 9 ADD 9 uses carry
    add(0, 1, 9,  1, 8'h07, 0, 0);
    add(0, 1, 10, 2, 8'h07, 0, 0);
    add(0, 1, 9,  3, 8'h07, 0, 0);
    add(0, 0, 0,  0, 8'h12, 1, 0);
    // 0 MUL 7
    add(0, 1, 0,  1, 8'h12, 0, 0);
    add(0, 1, 11, 2, 8'h12, 0, 0);
    add(0, 1, 7,  3, 8'h12, 0, 0);
    add(0, 0, 0,  3, 8'h12, 0, 0);
    add(0, 0, 0,  3, 8'h12, 0, 0);
    add(0, 0, 0,  3, 8'h12, 0, 0);
    add(0, 0, 0,  0, 8'h00, 1, 0);
    // keycode 13 in WAIT_B
    add(0, 1, 2,  1, 8'h00, 0, 0);
    add(0, 1, 10, 2, 8'h00, 0, 0);
    add(0, 1, 13, 2, 8'h00, 0, 1);
    add(0, 1, 3,  3, 8'h00, 0, 0);
    add(0, 0, 0,  0, 8'h05, 1, 0);
    // overwrites: 2,7,ADD,MUL,3 -> 7*3
    add(0, 1, 2,  1, 8'h05, 0, 0);
    add(0, 1, 7,  1, 8'h05, 0, 0);
    add(0, 1, 10, 2, 8'h05, 0, 0);
    add(0, 1, 11, 2, 8'h05, 0, 0);
    add(0, 1, 3,  3, 8'h05, 0, 0);
    add(0, 0, 0,  3, 8'h05, 0, 0);
    add(0, 0, 0,  3, 8'h05, 0, 0);
    add(0, 0, 0,  3, 8'h05, 0, 0);
    add(0, 0, 0,  0, 8'h15, 1, 0);
    // key during MUL EXEC
    add(0, 1, 9,  1, 8'h15, 0, 0);
    add(0, 1, 11, 2, 8'h15, 0, 0);
    add(0, 1, 9,  3, 8'h15, 0, 0);
    add(0, 1, 5,  3, 8'h15, 0, 1);
    add(0, 0, 0,  3, 8'h15, 0, 0);
    add(0, 0, 0,  3, 8'h15, 0, 0);
    add(0, 0, 0,  0, 8'h51, 1, 0);
    // invalid key in WAIT_OP, then 4 MUL 2
    add(0, 1, 4,  1, 8'h51, 0, 0);
    add(0, 1, 15, 1, 8'h51, 0, 1);
    add(0, 1, 11, 2, 8'h51, 0, 0);
    add(0, 1, 2,  3, 8'h51, 0, 0);
    add(0, 0, 0,  3, 8'h51, 0, 0);
    add(0, 0, 0,  3, 8'h51, 0, 0);
    add(0, 0, 0,  3, 8'h51, 0, 0);
    add(0, 0, 0,  0, 8'h08, 1, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].kv, tbl[i].kc);
      chk($sformatf("tbl%0d_state", i), 16'(state), 16'(tbl[i].st));
      chk($sformatf("tbl%0d_result", i), 16'(result), 16'(tbl[i].res));
      chk($sformatf("tbl%0d_rv", i), 16'(result_valid), 16'(tbl[i].rv));
      chk($sformatf("tbl%0d_err", i), 16'(err), 16'(tbl[i].er));
      chk($sformatf("tbl%0d_busy", i), 16'(busy), 16'(tbl[i].st == 2'd3));
    end

    // 9 MUL 9: four busy cycles, multiplier bits 1,0,0,1 select add_b, one pulse
    eb9 = '{9, 0, 0, 9};
    tick(0, 1, 9);
    tick(0, 1, 11);
    tick(0, 1, 9);
    cyc = 0;
    pulses = 0;
    while (busy && cyc < 10) begin
      if (cyc < 4) chk($sformatf("mul99_add_b%0d", cyc), 16'(add_b), 16'(eb9[cyc]));
      cyc++;
      tick(0, 0, 0);
      if (result_valid) pulses++;
    end
    chk("mul99_busy_cycles", 16'(cyc), 16'd4);
    tick(0, 0, 0);
    if (result_valid) pulses++;
    chk("mul99_pulses", 16'(pulses), 16'd1);
    chk("mul99_result", 16'(result), 16'h51);

    // 0 MUL 7: nothing is ever added
    tick(0, 1, 0);
    tick(0, 1, 11);
    tick(0, 1, 7);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("mul07_add_b%0d", s), 16'(add_b), 16'd0);
      tick(0, 0, 0);
    end
    chk("mul07_result", 16'(result), 16'h00);

    // reset on the second EXEC cycle of 5 MUL 6 aborts the operation
    tick(0, 1, 5);
    tick(0, 1, 11);
    tick(0, 1, 6);
    tick(0, 0, 0);
    chk("abort_in_exec", 16'(state), 16'd3);
    tick(1, 0, 0);
    chk("abort_state", 16'(state), 16'd0);
    chk("abort_result", 16'(result), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    rvs = int'(result_valid);
    for (int s = 0; s < 5; s++) begin
      tick(0, 0, 0);
      rvs += int'(result_valid);
    end
    chk("abort_no_rv", 16'(rvs), 16'd0);
    tick(0, 1, 2);
    tick(0, 1, 10);
    tick(0, 1, 2);
    tick(0, 0, 0);
    chk("after_abort_result", 16'(result), 16'h04);
    chk("after_abort_rv", 16'(result_valid), 16'd1);

    // randomized traffic against the model
    tick(1, 0, 0);
    check_model("rnd_reset");
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      kv = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 6)      kc = 4'($urandom_range(0, 9));
      else if (sel < 9) kc = 4'($urandom_range(10, 11));
      else              kc = 4'($urandom_range(12, 15));
      tick(r, kv, kc);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
